hazard_controller: RTL and testbench

- Central sequencing block for the 5-stage pipelined ARM-subset core: Fetch, Decode, Execute, Memory, Writeback.
- Generates the forwarding selects, stall enables and flush strobes for the pipeline registers.
- Holds the whole pipeline while a multi-cycle data-memory access is outstanding. A watchdog bounds that wait.
- Keeps saturating performance counters for stalls and flushes.
- Sits beside the datapath and the control unit; outputs drive the datapath stall, flush and forward inputs directly.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_controller.sv | 109 ++++++++++
 tb/tb_hazard_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard-controller bus: pipeline register fields, memory handshake and the
// stall/flush/forward controls returned to the datapath.
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       RA1D, RA2D, RA1E, RA2E;
   logic [3:0]       WA3E, WA3M, WA3W;
   logic             RegWriteM, RegWriteW, MemtoRegE;
   logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
   logic             BranchE, BranchTakenE, PredictedTakenE;
   logic             MemReqM, MemReadyM;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             MemWait, MemError;
   logic [CNT_W-1:0] StallCount, FlushCount;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
             RegWriteM, RegWriteW, MemtoRegE,
             PCSrcD, PCSrcE, PCSrcM, PCSrcW,
             BranchE, BranchTakenE, PredictedTakenE,
             MemReqM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemWait, MemError, StallCount, FlushCount
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
             RegWriteM, RegWriteW, MemtoRegE,
             PCSrcD, PCSrcE, PCSrcM, PCSrcW,
             BranchE, BranchTakenE, PredictedTakenE,
             MemReqM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemWait, MemError, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_controller.sv
// Hazard unit for the 5-stage ARM-subset pipeline: forwarding, load-use and
// PC-write stalls, mispredict flushes, memory-wait FSM with watchdog, counters.
module hazard_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic      CLK,
   input logic      RESET,
   hazard_if.slave  bus
);
   localparam int                 WAIT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [1:0]         FWD_RF    = 2'b00;
   localparam logic [1:0]         FWD_WB    = 2'b01;
   localparam logic [1:0]         FWD_MEM   = 2'b10;

   typedef enum logic {ST_RUN, ST_WAIT} mem_state_e;

   mem_state_e        state, state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_error;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   logic ld_stall, pc_stall, mispred, timeout, mem_stall;

   // R15 reads come from the PC path, so they are never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                          input logic       wr_m,
                                          input logic [3:0] dst_m,
                                          input logic       wr_w,
                                          input logic [3:0] dst_w);
      if (src == 4'd15)                 return FWD_RF;
      else if (wr_m && dst_m == src)    return FWD_MEM;
      else if (wr_w && dst_w == src)    return FWD_WB;
      else                              return FWD_RF;
   endfunction

   assign ld_stall = bus.MemtoRegE && (bus.WA3E == bus.RA1D || bus.WA3E == bus.RA2D);
   assign pc_stall = bus.PCSrcD || bus.PCSrcE || bus.PCSrcM;
   assign mispred  = bus.BranchE && (bus.BranchTakenE != bus.PredictedTakenE);
   assign timeout  = (state == ST_WAIT) && !bus.MemReadyM && (wait_cnt == WAIT_LAST);
   assign mem_stall = ((state == ST_RUN)  && bus.MemReqM && !bus.MemReadyM) ||
                      ((state == ST_WAIT) && !bus.MemReadyM && !timeout);

   assign bus.MemWait    = (state == ST_WAIT);
   assign bus.MemError   = mem_error;
   assign bus.StallCount = stall_cnt;
   assign bus.FlushCount = flush_cnt;

   // NOTE: every signal written in an always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      bus.ForwardAE = FWD_RF;
      bus.ForwardBE = FWD_RF;
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;
      bus.StallE    = 1'b0;
      bus.StallM    = 1'b0;
      bus.FlushD    = 1'b0;
      bus.FlushE    = 1'b0;
      bus.FlushW    = 1'b0;

      unique case (state)
         ST_RUN:  if (bus.MemReqM && !bus.MemReadyM)  state_next = ST_WAIT;
         ST_WAIT: if (bus.MemReadyM || timeout)       state_next = ST_RUN;
         default: state_next = ST_RUN;
      endcase

      if (!RESET) begin
         bus.ForwardAE = fwd_sel(bus.RA1E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
         bus.ForwardBE = fwd_sel(bus.RA2E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
         // A memory stall freezes the whole pipe; D/E hazards are re-evaluated on release.
         if (mem_stall) begin
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.StallE = 1'b1;
            bus.StallM = 1'b1;
            bus.FlushW = 1'b1;
         end else begin
            bus.StallF = ld_stall || (pc_stall && !bus.PCSrcW);
            bus.StallD = ld_stall && !mispred;
            bus.FlushD = pc_stall || mispred;
            bus.FlushE = ld_stall || mispred;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         mem_error <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_next;
         wait_cnt  <= (state == ST_WAIT && state_next == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         mem_error <= mem_error || timeout;
         if (bus.StallF && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
         if ((bus.FlushD || bus.FlushE) && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, hazards, memory wait,
// watchdog timeout, reset mid-wait and counter saturation (CNT_W = 4).
module tb_hazard_controller;
   logic clk;
   logic rst;
   int   vectors = 0;
   int   errors  = 0;

   hazard_if #(.CNT_W(4)) hif ();

   hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      hif.RA1D = 4'd0; hif.RA2D = 4'd0; hif.RA1E = 4'd0; hif.RA2E = 4'd0;
      hif.WA3E = 4'd0; hif.WA3M = 4'd0; hif.WA3W = 4'd0;
      hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.MemtoRegE = 1'b0;
      hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0; hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b0;
      hif.BranchE = 1'b0; hif.BranchTakenE = 1'b0; hif.PredictedTakenE = 1'b0;
      hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();

      // Hazards presented while in reset must be masked.
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd5; hif.RA2D = 4'd5;
      hif.RegWriteM = 1'b1; hif.WA3M = 4'd3; hif.RA1E = 4'd3;
      #1;
      check("rst_stallf", hif.StallF, 1'b0);
      check("rst_flushe", hif.FlushE, 1'b0);
      check("rst_fwda",   hif.ForwardAE, 2'b00);
      tick();
      check("rst_stallcnt", hif.StallCount, 4'd0);
      check("rst_flushcnt", hif.FlushCount, 4'd0);
      check("rst_memwait",  hif.MemWait, 1'b0);
      check("rst_memerr",   hif.MemError, 1'b0);
      clear_inputs();
      rst = 1'b0;

      // Forwarding: M beats W, W alone, R15 never forwarded.
      hif.RegWriteM = 1'b1; hif.WA3M = 4'd3; hif.RegWriteW = 1'b1; hif.WA3W = 4'd3;
      hif.RA1E = 4'd3; hif.RA2E = 4'd3;
      #1;
      check("fwd_a_mem", hif.ForwardAE, 2'b10);
      check("fwd_b_mem", hif.ForwardBE, 2'b10);
      hif.RegWriteM = 1'b0;
      #1;
      check("fwd_a_wb", hif.ForwardAE, 2'b01);
      hif.RegWriteM = 1'b1; hif.WA3M = 4'd4; hif.RA2E = 4'd4;
      #1;
      check("fwd_a_wb_mixed",  hif.ForwardAE, 2'b01);
      check("fwd_b_mem_mixed", hif.ForwardBE, 2'b10);
      hif.WA3M = 4'd15; hif.WA3W = 4'd15; hif.RA1E = 4'd15; hif.RA2E = 4'd15;
      #1;
      check("fwd_a_r15", hif.ForwardAE, 2'b00);
      check("fwd_b_r15", hif.ForwardBE, 2'b00);
      check("fwd_no_stall", hif.StallF, 1'b0);
      tick();
      clear_inputs();

      // Load-use: one cycle of StallF/StallD/FlushE.
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd5; hif.RA2D = 4'd5; hif.RA1D = 4'd1;
      #1;
      check("ld_stallf", hif.StallF, 1'b1);
      check("ld_stalld", hif.StallD, 1'b1);
      check("ld_flushe", hif.FlushE, 1'b1);
      check("ld_flushd", hif.FlushD, 1'b0);
      check("ld_stalle", hif.StallE, 1'b0);
      tick();
      clear_inputs();
      #1;
      check("ld_release", hif.StallF, 1'b0);
      check("ld_stallcnt", hif.StallCount, 4'd1);
      check("ld_flushcnt", hif.FlushCount, 4'd1);

      // Mispredict on top of load-use squashes D instead of stalling it.
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd5; hif.RA2D = 4'd5;
      hif.BranchE = 1'b1; hif.BranchTakenE = 1'b1; hif.PredictedTakenE = 1'b0;
      #1;
      check("mp_flushd", hif.FlushD, 1'b1);
      check("mp_flushe", hif.FlushE, 1'b1);
      check("mp_stalld", hif.StallD, 1'b0);
      check("mp_stallf", hif.StallF, 1'b1);
      tick();
      clear_inputs();
      #1;
      check("mp_stallcnt", hif.StallCount, 4'd2);
      check("mp_flushcnt", hif.FlushCount, 4'd2);

      // PC-write hazard, then PCSrcW drops StallF in the same cycle.
      hif.PCSrcE = 1'b1;
      #1;
      check("pc_stallf", hif.StallF, 1'b1);
      check("pc_flushd", hif.FlushD, 1'b1);
      check("pc_flushe", hif.FlushE, 1'b0);
      tick();
      hif.PCSrcW = 1'b1;
      #1;
      check("pcw_stallf", hif.StallF, 1'b0);
      check("pcw_flushd", hif.FlushD, 1'b1);
      tick();
      clear_inputs();
      #1;
      check("pc_stallcnt", hif.StallCount, 4'd3);
      check("pc_flushcnt", hif.FlushCount, 4'd4);

      // Memory wait: ready low for 3 cycles, then high.
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      hif.BranchE = 1'b1; hif.BranchTakenE = 1'b1; hif.PredictedTakenE = 1'b0;
      #1;
      check("mw1_stallf",  hif.StallF, 1'b1);
      check("mw1_stallm",  hif.StallM, 1'b1);
      check("mw1_flushw",  hif.FlushW, 1'b1);
      check("mw1_flushd",  hif.FlushD, 1'b0);
      check("mw1_flushe",  hif.FlushE, 1'b0);
      check("mw1_memwait", hif.MemWait, 1'b0);
      tick();
      hif.BranchE = 1'b0; hif.BranchTakenE = 1'b0;
      #1;
      check("mw2_stalle",  hif.StallE, 1'b1);
      check("mw2_memwait", hif.MemWait, 1'b1);
      tick();
      #1;
      check("mw3_stalld",  hif.StallD, 1'b1);
      check("mw3_memwait", hif.MemWait, 1'b1);
      tick();
      hif.MemReadyM = 1'b1;
      #1;
      check("mw4_stallf",  hif.StallF, 1'b0);
      check("mw4_flushw",  hif.FlushW, 1'b0);
      check("mw4_memwait", hif.MemWait, 1'b1);
      tick();
      clear_inputs();
      #1;
      check("mw_run",      hif.MemWait, 1'b0);
      check("mw_memerr",   hif.MemError, 1'b0);
      check("mw_stallcnt", hif.StallCount, 4'd6);
      check("mw_flushcnt", hif.FlushCount, 4'd4);

      // Ready in the same cycle as the request: no stall, no WAIT.
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
      #1;
      check("rdy_stallf", hif.StallF, 1'b0);
      tick();
      #1;
      check("rdy_memwait", hif.MemWait, 1'b0);
      clear_inputs();

      // Watchdog: 16 stalled cycles, the 17th is released with MemError.
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         #1;
         check($sformatf("to_stall_%0d", i), hif.StallF, 1'b1);
         tick();
      end
      #1;
      check("to_release", hif.StallF, 1'b0);
      check("to_flushw",  hif.FlushW, 1'b0);
      check("to_memwait", hif.MemWait, 1'b1);
      tick();
      #1;
      check("to_run",      hif.MemWait, 1'b0);
      check("to_memerr",   hif.MemError, 1'b1);
      check("to_restall",  hif.StallF, 1'b1);
      check("to_stallcnt", hif.StallCount, 4'd15);
      tick();
      #1;
      check("to_rewait",    hif.MemWait, 1'b1);
      check("to_err_stick", hif.MemError, 1'b1);

      // Reset in the middle of WAIT.
      rst = 1'b1;
      #1;
      check("rstw_stallf", hif.StallF, 1'b0);
      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      check("rstw_memwait",  hif.MemWait, 1'b0);
      check("rstw_memerr",   hif.MemError, 1'b0);
      check("rstw_stallcnt", hif.StallCount, 4'd0);
      check("rstw_flushcnt", hif.FlushCount, 4'd0);

      // Saturation: 20 load-use cycles on a 4-bit counter.
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd5; hif.RA1D = 4'd5;
      for (int i = 0; i < 20; i++) tick();
      #1;
      check("sat_stallcnt", hif.StallCount, 4'd15);
      check("sat_flushcnt", hif.FlushCount, 4'd15);
      clear_inputs();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
